mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store execution unit that consumes the memory-control outputs of the instruction decoder (mem_read, mem_write, mem_acc_mode) plus the ALU-computed address and store data. It performs one word, halfword or byte access per request on a simple req/ack data bus. For loads it returns zero-extended read data (lw/lhu/lbu); for stores it drives byte-lane enables (sw/sh/sb). It stalls the core while a bus transaction is outstanding, and flags misaligned or timed-out accesses.

Parameters:
TIMEOUT, 16, number of cycles bus_req may wait for bus_ack before the access is aborted with err; 0 disables the timeout.
ADDR_W, 32, address width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  core presents an access this cycle
req_ready  output  1  unit can accept a request (high only in IDLE)
mem_read  input  1  load request (from decoder)
mem_write  input  1  store request (from decoder)
mem_acc_mode  input  2  `MEM_MODE_WORD=2'b00, `MEM_MODE_HWORD=2'b01, `MEM_MODE_BYTE=2'b10; 2'b11 reserved, treated as WORD
addr  input  ADDR_W  byte address (ALU result)
wdata  input  32  store data; only the low byte or halfword is used for sb/sh
stall  output  1  high from acceptance until the cycle done is asserted
done  output  1  one-cycle pulse when the access completes (success or error)
rdata  output  32  zero-extended load result, valid while done=1
err  output  1  one-cycle pulse with done on misalignment, invalid request or timeout
bus_req  output  1  bus request, held until bus_ack
bus_we  output  1  1 = write
bus_addr  output  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
bus_be  output  4  byte enables; bit i maps to bits 8i+7:8i (little-endian)
bus_wdata  output  32  store data replicated onto the selected lanes
bus_ack  input  1  bus completes the transaction; bus_rdata is valid in the same cycle
bus_rdata  input  32  bus read data

Behaviour:
- Reset (async, any state): state IDLE; req_ready=1. stall, done, err, bus_req and bus_we are 0. bus_addr, bus_be, bus_wdata, rdata and the timeout counter are 0. Reset during REQ drops bus_req immediately; the transaction is abandoned.
- Accept condition: req_valid & req_ready & (mem_read|mem_write). req_valid with neither read nor write set is ignored: not accepted, no response.
- States: IDLE, REQ, DONE.
- IDLE -> REQ on accept with a valid, aligned request. All request fields are registered at acceptance. Next cycle: bus_req=1, stall=1.
- IDLE -> DONE with err=1, and no bus cycle, in two cases:
  - mem_read & mem_write both set;
  - misaligned access: HWORD with addr[0]=1, or WORD with addr[1:0]!=0.
- REQ: bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable until bus_ack. On bus_ack: deassert bus_req the next cycle and go to DONE. For loads, capture the lane-selected bus_rdata:
  - BYTE: {24'b0, byte lane addr[1:0]}
  - HWORD: {16'b0, halfword lane addr[1]}
  - WORD: full word.
- Timeout: the counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 with no ack, go to DONE with err=1 and drop bus_req. An ack arriving in that same cycle wins (success).
- DONE: done=1 for exactly one cycle; rdata is valid for loads and 0 for stores and errors; stall=0. Next state is IDLE.
- Latency: accept at cycle N -> bus_req at N+1 -> ack at cycle M (M>=N+1) -> done at M+1. Minimum 2-cycle load-to-result. Error path: done at N+1.
- Byte enables and store data:
  - BYTE: be = 4'b0001<<addr[1:0], wdata[7:0] replicated on all 4 lanes.
  - HWORD: be = addr[1] ? 4'b1100 : 4'b0011, wdata[15:0] replicated on both halves.
  - WORD: be = 4'b1111.
  - Loads drive be=4'b1111 and bus_we=0.
- stall is 1 while the state is REQ or the request has just been accepted. req_ready = (state==IDLE). No back-to-back acceptance: a new request is accepted at the earliest one cycle after done.
- bus_ack outside REQ is ignored.

Test Plan:
- Load word, addr=0x100, bus_rdata=0xDEADBEEF, ack after 3 cycles -> bus_addr=0x100, be=1111, done 1 cycle after ack, rdata=0xDEADBEEF, err=0.
- lbu addr=0x103, bus_rdata=0x8877AABB -> be=1111, rdata=0x00000088; lhu addr=0x102 with same data -> rdata=0x00008877.
- sb addr=0x201 wdata=0x123456AB -> bus_addr=0x200, be=0010, bus_wdata=0xABABABAB, bus_we=1; sh addr=0x202 wdata=0xCAFE -> be=1100, bus_wdata=0xCAFECAFE.
- Misaligned lw addr=0x102, and a request with mem_read=mem_write=1 -> bus_req never asserts, done=err=1 at N+1, rdata=0.
- TIMEOUT=4, no ack -> bus_req high 4 cycles then low, done=err=1; repeat with ack in the 4th cycle -> err=0.
- Assert rst while bus_req=1 -> bus_req/stall go 0 without a clock edge, req_ready=1; the next access completes normally.

Source files
------------

// File: rtl/mem_access_if.sv
// Core-side request/response and simple req/ack data-bus signals of the load/store unit.
interface mem_access_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              mem_read;
   logic              mem_write;
   logic [1:0]        mem_acc_mode;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              stall;
   logic              done;
   logic [31:0]       rdata;
   logic              err;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [3:0]        bus_be;
   logic [31:0]       bus_wdata;
   logic              bus_ack;
   logic [31:0]       bus_rdata;

   modport slave (
      input  req_valid, mem_read, mem_write, mem_acc_mode, addr, wdata, bus_ack, bus_rdata,
      output req_ready, stall, done, rdata, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
   );

   modport master (
      output req_valid, mem_read, mem_write, mem_acc_mode, addr, wdata, bus_ack, bus_rdata,
      input  req_ready, stall, done, rdata, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one word/halfword/byte access per request over a req/ack bus.
//   state  | meaning
//   IDLE   | ready for a request
//   REQ    | bus_req held, waiting for bus_ack or timeout
//   DONE   | one-cycle completion pulse (done, optional err, rdata)
module mem_access_unit #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input logic         clk,
   input logic         rst,
   mem_access_if.slave mif
);
   localparam logic [1:0] MODE_WORD  = 2'b00;
   localparam logic [1:0] MODE_HWORD = 2'b01;
   localparam logic [1:0] MODE_BYTE  = 2'b10;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   logic [1:0]       state;
   logic [1:0]       mode_q;
   logic [1:0]       lane_q;
   logic             load_q;
   logic [CNT_W-1:0] cnt;

   logic [1:0]  mode_eff;
   logic        misaligned;
   logic        accept;
   logic        bad_req;
   logic        timed_out;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   assign mif.req_ready = (state == S_IDLE);
   assign mif.stall     = (state == S_REQ);

   // Reserved mode 2'b11 behaves exactly like a word access
   assign mode_eff   = (mif.mem_acc_mode == 2'b11) ? MODE_WORD : mif.mem_acc_mode;
   assign misaligned = ((mode_eff == MODE_HWORD) && mif.addr[0]) ||
                       ((mode_eff == MODE_WORD) && (mif.addr[1:0] != 2'b00));
   assign accept     = mif.req_valid && (state == S_IDLE) && (mif.mem_read || mif.mem_write);
   assign bad_req    = (mif.mem_read && mif.mem_write) || misaligned;
   assign timed_out  = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = 32'h0;
      if (mif.mem_write) begin
         case (mode_eff)
            MODE_BYTE: begin
               be_calc    = 4'b0001 << mif.addr[1:0];
               wdata_calc = {4{mif.wdata[7:0]}};
            end
            MODE_HWORD: begin
               be_calc    = mif.addr[1] ? 4'b1100 : 4'b0011;
               wdata_calc = {2{mif.wdata[15:0]}};
            end
            default: begin
               be_calc    = 4'b1111;
               wdata_calc = mif.wdata;
            end
         endcase
      end
   end

   always_comb begin
      case (lane_q)
         2'd1:    byte_sel = mif.bus_rdata[15:8];
         2'd2:    byte_sel = mif.bus_rdata[23:16];
         2'd3:    byte_sel = mif.bus_rdata[31:24];
         default: byte_sel = mif.bus_rdata[7:0];
      endcase
      half_sel = lane_q[1] ? mif.bus_rdata[31:16] : mif.bus_rdata[15:0];
      case (mode_q)
         MODE_BYTE:  load_data = {24'b0, byte_sel};
         MODE_HWORD: load_data = {16'b0, half_sel};
         default:    load_data = mif.bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         mode_q        <= MODE_WORD;
         lane_q        <= 2'b00;
         load_q        <= 1'b0;
         cnt           <= '0;
         mif.done      <= 1'b0;
         mif.err       <= 1'b0;
         mif.rdata     <= 32'h0;
         mif.bus_req   <= 1'b0;
         mif.bus_we    <= 1'b0;
         mif.bus_addr  <= '0;
         mif.bus_be    <= 4'b0000;
         mif.bus_wdata <= 32'h0;
      end else begin
         mif.done <= 1'b0;
         mif.err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (bad_req) begin
                     state     <= S_DONE;
                     mif.done  <= 1'b1;
                     mif.err   <= 1'b1;
                     mif.rdata <= 32'h0;
                  end else begin
                     state         <= S_REQ;
                     mif.bus_req   <= 1'b1;
                     mif.bus_we    <= mif.mem_write;
                     mif.bus_addr  <= {mif.addr[ADDR_W-1:2], 2'b00};
                     mif.bus_be    <= be_calc;
                     mif.bus_wdata <= wdata_calc;
                     mode_q        <= mode_eff;
                     lane_q        <= mif.addr[1:0];
                     load_q        <= mif.mem_read;
                     cnt           <= '0;
                  end
               end
            end
            S_REQ: begin
               // An ack in the final timeout cycle still completes successfully
               if (mif.bus_ack) begin
                  state       <= S_DONE;
                  mif.bus_req <= 1'b0;
                  mif.bus_we  <= 1'b0;
                  mif.done    <= 1'b1;
                  mif.rdata   <= load_q ? load_data : 32'h0;
               end else if (timed_out) begin
                  state       <= S_DONE;
                  mif.bus_req <= 1'b0;
                  mif.bus_we  <= 1'b0;
                  mif.done    <= 1'b1;
                  mif.err     <= 1'b1;
                  mif.rdata   <= 32'h0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               mif.rdata <= 32'h0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_if #(.ADDR_W(32)) mif();

   mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .mif (mif.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   logic        exp_ready, exp_stall, exp_done, exp_err, exp_breq, exp_we;
   logic [31:0] exp_rdata, exp_addr, exp_wdata;
   logic [3:0]  exp_be;

   int          breq_total = 0;
   logic [31:0] last_rdata, last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_err, last_we;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("req_ready", 32'(mif.req_ready), 32'(exp_ready));
         check("stall",     32'(mif.stall),     32'(exp_stall));
         check("done",      32'(mif.done),      32'(exp_done));
         check("err",       32'(mif.err),       32'(exp_err));
         check("bus_req",   32'(mif.bus_req),   32'(exp_breq));
         if (exp_done) check("rdata", mif.rdata, exp_rdata);
         if (exp_breq) begin
            check("bus_we",   32'(mif.bus_we), 32'(exp_we));
            check("bus_addr", mif.bus_addr,    exp_addr);
            check("bus_be",   32'(mif.bus_be), 32'(exp_be));
            if (exp_we) check("bus_wdata", mif.bus_wdata, exp_wdata);
         end
      end
      if (mif.bus_req) begin
         breq_total++;
         last_addr  = mif.bus_addr;
         last_be    = mif.bus_be;
         last_wdata = mif.bus_wdata;
         last_we    = mif.bus_we;
      end
      if (mif.done) begin
         last_rdata = mif.rdata;
         last_err   = mif.err;
      end
   end

   task automatic set_idle_exp();
      exp_ready = 1'b1; exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_breq = 1'b0;
   endtask

   task automatic set_done_exp(input logic e, input logic [31:0] r);
      exp_ready = 1'b0; exp_stall = 1'b0; exp_done = 1'b1; exp_err = e; exp_breq = 1'b0;
      exp_rdata = r;
   endtask

   // Request inputs become don't-care once the unit is busy
   task automatic scramble();
      mif.req_valid    = 1'($urandom_range(0, 1));
      mif.mem_read     = 1'($urandom_range(0, 1));
      mif.mem_write    = 1'($urandom_range(0, 1));
      mif.mem_acc_mode = 2'($urandom_range(0, 3));
      mif.addr         = $urandom;
      mif.wdata        = $urandom;
   endtask

   function automatic logic [31:0] model_load(input logic [1:0] m, input logic [31:0] a,
                                              input logic [31:0] d);
      if (m == 2'b10) return (d >> (int'(a[1:0]) * 8)) & 32'h0000_00FF;
      if (m == 2'b01) return (d >> (int'(a[1]) * 16)) & 32'h0000_FFFF;
      return d;
   endfunction

   // ack_k: REQ cycle (1-based) in which bus_ack is given; 0 means never
   task automatic run_access(input logic rd, input logic wr, input logic [1:0] m,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] bd, input int ack_k);
      logic [1:0] me;
      logic       bad;
      logic       finished;
      me  = (m == 2'b11) ? 2'b00 : m;
      bad = (rd && wr) || (me == 2'b01 && a[0]) || (me == 2'b00 && a[1:0] != 2'b00);
      set_idle_exp();
      mif.req_valid = 1'b1; mif.mem_read = rd; mif.mem_write = wr;
      mif.mem_acc_mode = m; mif.addr = a; mif.wdata = wd;
      mif.bus_ack = 1'b0; mif.bus_rdata = $urandom;
      @(posedge clk); #1;
      if (!rd && !wr) begin
         set_idle_exp();
         mif.req_valid = 1'b0;
         return;
      end
      if (bad) begin
         set_done_exp(1'b1, 32'h0);
      end else begin
         finished = 1'b0;
         for (int k = 1; k <= TO && !finished; k++) begin
            exp_ready = 1'b0; exp_stall = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
            exp_breq = 1'b1; exp_we = wr; exp_addr = {a[31:2], 2'b00};
            if (!wr)              begin exp_be = 4'b1111; exp_wdata = 32'h0; end
            else if (me == 2'b10) begin exp_be = 4'(1 << a[1:0]); exp_wdata = {4{wd[7:0]}}; end
            else if (me == 2'b01) begin exp_be = a[1] ? 4'b1100 : 4'b0011; exp_wdata = {2{wd[15:0]}}; end
            else                  begin exp_be = 4'b1111; exp_wdata = wd; end
            mif.bus_ack   = (k == ack_k);
            mif.bus_rdata = (k == ack_k) ? bd : $urandom;
            scramble();
            @(posedge clk); #1;
            if (k == ack_k) begin
               set_done_exp(1'b0, rd ? model_load(me, a, bd) : 32'h0);
               finished = 1'b1;
            end else if (k == TO) begin
               set_done_exp(1'b1, 32'h0);
               finished = 1'b1;
            end
         end
      end
      mif.bus_ack = 1'($urandom_range(0, 1));
      mif.bus_rdata = $urandom;
      scramble();
      @(posedge clk); #1;
      set_idle_exp();
      mif.req_valid = 1'b0;
      mif.bus_ack   = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         set_idle_exp();
         mif.req_valid = 1'b0;
         mif.bus_ack   = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      set_idle_exp();
      mif.bus_ack = 1'b0;
   endtask

   int base;

   initial begin
      mif.req_valid = 1'b0; mif.mem_read = 1'b0; mif.mem_write = 1'b0;
      mif.mem_acc_mode = 2'b00; mif.addr = 32'h0; mif.wdata = 32'h0;
      mif.bus_ack = 1'b0; mif.bus_rdata = 32'h0;
      exp_we = 1'b0; exp_rdata = 32'h0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0;
      set_idle_exp();
      #1;
      check("rst_req_ready", 32'(mif.req_ready), 32'd1);
      check("rst_stall",     32'(mif.stall),     32'd0);
      check("rst_done",      32'(mif.done),      32'd0);
      check("rst_err",       32'(mif.err),       32'd0);
      check("rst_bus_req",   32'(mif.bus_req),   32'd0);
      check("rst_bus_we",    32'(mif.bus_we),    32'd0);
      check("rst_bus_addr",  mif.bus_addr,       32'd0);
      check("rst_bus_be",    32'(mif.bus_be),    32'd0);
      check("rst_bus_wdata", mif.bus_wdata,      32'd0);
      check("rst_rdata",     mif.rdata,          32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      idle_cycles(2);

      base = breq_total;
      run_access(1, 0, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 3);
      check("lw_addr",  last_addr, 32'h100);
      check("lw_be",    32'(last_be), 32'hF);
      check("lw_rdata", last_rdata, 32'hDEADBEEF);
      check("lw_err",   32'(last_err), 32'd0);
      check("lw_breq_cycles", 32'(breq_total - base), 32'd3);

      run_access(1, 0, 2'b10, 32'h103, 32'h0, 32'h8877AABB, 1);
      check("lbu_be",    32'(last_be), 32'hF);
      check("lbu_rdata", last_rdata, 32'h00000088);
      run_access(1, 0, 2'b01, 32'h102, 32'h0, 32'h8877AABB, 2);
      check("lhu_rdata", last_rdata, 32'h00008877);

      run_access(0, 1, 2'b10, 32'h201, 32'h123456AB, 32'h0, 1);
      check("sb_addr",  last_addr, 32'h200);
      check("sb_be",    32'(last_be), 32'h2);
      check("sb_wdata", last_wdata, 32'hABABABAB);
      check("sb_we",    32'(last_we), 32'd1);
      run_access(0, 1, 2'b01, 32'h202, 32'h0000CAFE, 32'h0, 2);
      check("sh_be",    32'(last_be), 32'hC);
      check("sh_wdata", last_wdata, 32'hCAFECAFE);

      base = breq_total;
      run_access(1, 0, 2'b00, 32'h102, 32'h0, 32'h0, 1);
      check("mis_err", 32'(last_err), 32'd1);
      run_access(1, 1, 2'b00, 32'h100, 32'h0, 32'h0, 1);
      check("rw_err", 32'(last_err), 32'd1);
      check("err_no_bus", 32'(breq_total - base), 32'd0);

      base = breq_total;
      run_access(1, 0, 2'b00, 32'h40, 32'h0, 32'h0, 0);
      check("to_err", 32'(last_err), 32'd1);
      check("to_breq_cycles", 32'(breq_total - base), 32'd4);
      base = breq_total;
      run_access(1, 0, 2'b00, 32'h44, 32'h0, 32'h11223344, 4);
      check("ack_last_err", 32'(last_err), 32'd0);
      check("ack_last_rdata", last_rdata, 32'h11223344);
      check("ack_last_breq_cycles", 32'(breq_total - base), 32'd4);

      run_access(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1);
      idle_cycles(1);

      // Asynchronous reset in the middle of a bus request
      chk_en = 1'b0;
      mif.req_valid = 1'b1; mif.mem_read = 1'b1; mif.mem_write = 1'b0;
      mif.mem_acc_mode = 2'b00; mif.addr = 32'h300;
      @(posedge clk); #1;
      mif.req_valid = 1'b0;
      check("pre_rst_bus_req", 32'(mif.bus_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_bus_req",   32'(mif.bus_req),   32'd0);
      check("async_rst_stall",     32'(mif.stall),     32'd0);
      check("async_rst_req_ready", 32'(mif.req_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      set_idle_exp();
      chk_en = 1'b1;
      run_access(1, 0, 2'b00, 32'h300, 32'h0, 32'hA5A5A5A5, 2);
      check("post_rst_rdata", last_rdata, 32'hA5A5A5A5);

      for (int t = 0; t < 250; t++) begin
         int sel;
         logic rd, wr;
         sel = $urandom_range(0, 9);
         rd = (sel == 1) || (sel >= 2 && sel <= 5);
         wr = (sel == 1) || (sel >= 6);
         run_access(rd, wr, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                    $urandom_range(0, 6));
         idle_cycles($urandom_range(0, 2));
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
